uart_alu_sequencer: RTL and testbench
=====================================

// Module: uart_alu_sequencer
// PURPOSE
// - Command sequencer between the UART receiver/transmitter and the ALU.
// - Collects 3 received bytes in order: operand A, operand B, opcode.
// - Presents them to the combinational ALU, then sends the 8-bit result back through the UART transmitter.
// - Aborts a partial command after an inter-byte timeout.
// PARAMETERS
// - WIDTH_WORD      8     data/operand/result width (one UART word)
// - WIDTH_OP        6     ALU opcode width; taken from o_alu_op <= i_rx_data[WIDTH_OP-1:0]
// - TIMEOUT_CYCLES  50000 idle i_clock cycles allowed in WAIT_B/WAIT_OP; must be >= 2
// PORTS
// - i_clock       in   1           system clock, rising edge
// - i_reset       in   1           reset, synchronous, active-low
// - i_rx_done     in   1           1-cycle pulse: i_rx_data holds a new received word
// - i_rx_data     in   WIDTH_WORD  received word, valid only while i_rx_done=1
// - i_alu_result  in   WIDTH_WORD  combinational ALU result of o_alu_a/o_alu_b/o_alu_op
// - i_tx_done     in   1           1-cycle pulse: transmitter finished current word
// - o_alu_a       out  WIDTH_WORD  operand A register
// - o_alu_b       out  WIDTH_WORD  operand B register
// - o_alu_op      out  WIDTH_OP    opcode register
// - o_tx_start    out  1           1-cycle pulse: start transmission of o_tx_data
// - o_tx_data     out  WIDTH_WORD  word to transmit (captured result)
// - o_busy        out  1           1 in every state except WAIT_A
// - o_timeout     out  1           1-cycle pulse: partial command discarded by timeout
// - o_overrun     out  1           1-cycle pulse: i_rx_done dropped while busy executing/sending
// BEHAVIOUR
// - Reset (i_reset=0 at rising edge):
//   - state = WAIT_A; all outputs and the timeout counter = 0.
//   - Applies in any state, including mid-command or mid-transmission.
// - WAIT_A:
//   - On i_rx_done: o_alu_a <= i_rx_data; go to WAIT_B.
// - WAIT_B:
//   - On i_rx_done: o_alu_b <= i_rx_data; go to WAIT_OP.
// - WAIT_OP:
//   - On i_rx_done: o_alu_op <= i_rx_data[WIDTH_OP-1:0]; go to EXEC.
// - EXEC (exactly 1 cycle; lets the ALU settle on the new operands):
//   - o_tx_data <= i_alu_result; go to SEND.
// - SEND (exactly 1 cycle):
//   - o_tx_start = 1 for this cycle only; go to WAIT_TX.
//   - o_tx_data is stable from the SEND cycle until the next EXEC.
// - WAIT_TX:
//   - On i_tx_done: go to WAIT_A.
//   - i_tx_done is ignored in all other states.
// - Latency: opcode i_rx_done at edge N -> o_tx_start high in cycle N+2 (EXEC = N+1, SEND = N+2).
// - o_alu_a/o_alu_b/o_alu_op hold their last values until overwritten; they are not cleared by timeout.
// - Timeout counter (width $clog2(TIMEOUT_CYCLES)):
//   - Cleared on entry to WAIT_B/WAIT_OP and in all other states.
//   - Increments each cycle in WAIT_B/WAIT_OP without i_rx_done.
//   - When counter == TIMEOUT_CYCLES-1 and i_rx_done=0: o_timeout=1 that cycle; next state WAIT_A.
//   - Result: exactly TIMEOUT_CYCLES idle cycles trigger the abort.
//   - i_rx_done in the same cycle as the timeout condition: the byte wins; no timeout.
// - i_rx_done in EXEC/SEND/WAIT_TX:
//   - Byte discarded; o_overrun=1 that cycle; state and registers unchanged.
// - No timeout in WAIT_A or WAIT_TX.
// - Illegal state encoding -> WAIT_A next cycle; outputs unchanged.
// TESTING
// - Normal: rx A=0x05, B=0x03, OP=0x20 (ALU add model)
//   -> o_tx_start pulse 2 cycles after OP; o_tx_data=0x08.
//   -> i_tx_done returns o_busy to 0.
// - Back-to-back: two full commands, second sent 1 cycle after first i_tx_done
//   -> two tx pulses with correct results; no o_overrun.
// - Timeout: rx A only, then TIMEOUT_CYCLES idle cycles
//   -> o_timeout pulse on the last idle cycle; state WAIT_A.
//   -> next 3 bytes form a new command.
// - Timeout boundary: rx_done on cycle TIMEOUT_CYCLES-1 after B
//   -> no timeout; byte accepted as opcode.
// - Overrun: rx_done during WAIT_TX
//   -> o_overrun pulse; o_tx_data unchanged; next command decodes correctly.
// - Reset mid-command after B, and again during WAIT_TX
//   -> all outputs 0, o_busy=0; fresh command works.

Source files
------------

// File: rtl/uart_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : uart_alu_sequencer
// Brief   : Gathers operand A, operand B and opcode from the UART, drives the
//           ALU, then returns the result through the UART transmitter.
// Revision: 1.0 - initial release
// ============================================================================
module uart_alu_sequencer #(
    parameter int WIDTH_WORD     = 8,
    parameter int WIDTH_OP       = 6,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_rx_done,
    input  logic [WIDTH_WORD-1:0] i_rx_data,
    input  logic [WIDTH_WORD-1:0] i_alu_result,
    input  logic                  i_tx_done,
    output logic [WIDTH_WORD-1:0] o_alu_a,
    output logic [WIDTH_WORD-1:0] o_alu_b,
    output logic [WIDTH_OP-1:0]   o_alu_op,
    output logic                  o_tx_start,
    output logic [WIDTH_WORD-1:0] o_tx_data,
    output logic                  o_busy,
    output logic                  o_timeout,
    output logic                  o_overrun
);

    localparam int c_CNT_W = ($clog2(TIMEOUT_CYCLES) > 0) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] c_WAIT_A  = 3'd0;
    localparam logic [2:0] c_WAIT_B  = 3'd1;
    localparam logic [2:0] c_WAIT_OP = 3'd2;
    localparam logic [2:0] c_EXEC    = 3'd3;
    localparam logic [2:0] c_SEND    = 3'd4;
    localparam logic [2:0] c_WAIT_TX = 3'd5;

    logic [2:0]            r_state;
    logic [2:0]            w_state_next;
    logic [c_CNT_W-1:0]    r_timer;
    logic [WIDTH_WORD-1:0] r_alu_a;
    logic [WIDTH_WORD-1:0] r_alu_b;
    logic [WIDTH_OP-1:0]   r_alu_op;
    logic [WIDTH_WORD-1:0] r_tx_data;

    logic w_in_wait;
    logic w_timer_last;
    logic w_load_a;
    logic w_load_b;
    logic w_load_op;
    logic w_capture;
    logic w_tx_start;
    logic w_busy;
    logic w_timeout;
    logic w_overrun;

    assign w_in_wait    = (r_state == c_WAIT_B) || (r_state == c_WAIT_OP);
    assign w_timer_last = (r_timer == c_CNT_LAST);

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state <= c_WAIT_A;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_WAIT_A:  if (i_rx_done) w_state_next = c_WAIT_B;
            c_WAIT_B: begin
                if (i_rx_done)         w_state_next = c_WAIT_OP;
                else if (w_timer_last) w_state_next = c_WAIT_A;
            end
            c_WAIT_OP: begin
                if (i_rx_done)         w_state_next = c_EXEC;
                else if (w_timer_last) w_state_next = c_WAIT_A;
            end
            c_EXEC:    w_state_next = c_SEND;
            c_SEND:    w_state_next = c_WAIT_TX;
            c_WAIT_TX: if (i_tx_done) w_state_next = c_WAIT_A;
            default:   w_state_next = c_WAIT_A;
        endcase
    end

    // A byte arriving on the timeout cycle takes priority over the abort.
    always_comb begin
        w_load_a   = (r_state == c_WAIT_A)  && i_rx_done;
        w_load_b   = (r_state == c_WAIT_B)  && i_rx_done;
        w_load_op  = (r_state == c_WAIT_OP) && i_rx_done;
        w_capture  = (r_state == c_EXEC);
        w_tx_start = (r_state == c_SEND);
        w_busy     = (r_state != c_WAIT_A);
        w_timeout  = w_in_wait && !i_rx_done && w_timer_last;
        w_overrun  = i_rx_done && ((r_state == c_EXEC) || (r_state == c_SEND) ||
                                   (r_state == c_WAIT_TX));
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_op  <= '0;
            r_tx_data <= '0;
            r_timer   <= '0;
        end else begin
            if (w_load_a)  r_alu_a   <= i_rx_data;
            if (w_load_b)  r_alu_b   <= i_rx_data;
            if (w_load_op) r_alu_op  <= i_rx_data[WIDTH_OP-1:0];
            if (w_capture) r_tx_data <= i_alu_result;
            if (w_in_wait && !i_rx_done) begin
                r_timer <= r_timer + 1'b1;
            end else begin
                r_timer <= '0;
            end
        end
    end

    assign o_alu_a    = r_alu_a;
    assign o_alu_b    = r_alu_b;
    assign o_alu_op   = r_alu_op;
    assign o_tx_data  = r_tx_data;
    assign o_tx_start = w_tx_start;
    assign o_busy     = w_busy;
    assign o_timeout  = w_timeout;
    assign o_overrun  = w_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_alu_sequencer
// Brief   : Scoreboard bench for uart_alu_sequencer with a small ALU model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_alu_sequencer;

    localparam int c_T = 16;

    logic       clk = 1'b0;
    logic       i_reset = 1'b0;
    logic       i_rx_done = 1'b0;
    logic [7:0] i_rx_data = 8'h00;
    logic [7:0] i_alu_result;
    logic       i_tx_done = 1'b0;
    logic [7:0] o_alu_a;
    logic [7:0] o_alu_b;
    logic [5:0] o_alu_op;
    logic       o_tx_start;
    logic [7:0] o_tx_data;
    logic       o_busy;
    logic       o_timeout;
    logic       o_overrun;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    typedef struct {
        logic [7:0] data;
        int         when;
    } tx_t;

    tx_t q_tx[$];
    int  q_to[$];
    int  q_ov[$];

    uart_alu_sequencer #(
        .WIDTH_WORD    (8),
        .WIDTH_OP      (6),
        .TIMEOUT_CYCLES(c_T)
    ) u_dut (
        .i_clock     (clk),
        .i_reset     (i_reset),
        .i_rx_done   (i_rx_done),
        .i_rx_data   (i_rx_data),
        .i_alu_result(i_alu_result),
        .i_tx_done   (i_tx_done),
        .o_alu_a     (o_alu_a),
        .o_alu_b     (o_alu_b),
        .o_alu_op    (o_alu_op),
        .o_tx_start  (o_tx_start),
        .o_tx_data   (o_tx_data),
        .o_busy      (o_busy),
        .o_timeout   (o_timeout),
        .o_overrun   (o_overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ALU model: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x26 xor
    always_comb begin
        i_alu_result = 8'h00;
        case (o_alu_op)
            6'h20: i_alu_result = o_alu_a + o_alu_b;
            6'h22: i_alu_result = o_alu_a - o_alu_b;
            6'h24: i_alu_result = o_alu_a & o_alu_b;
            6'h25: i_alu_result = o_alu_a | o_alu_b;
            6'h26: i_alu_result = o_alu_a ^ o_alu_b;
            default: i_alu_result = 8'h00;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: samples on the falling edge, away from input changes.
    always @(negedge clk) begin
        tx_t e;
        int  w;
        if (o_tx_start) begin
            if (q_tx.size() == 0) begin
                check("unexpected_tx_start", 32'd1, 32'd0);
            end else begin
                e = q_tx.pop_front();
                check("tx_data", {24'd0, o_tx_data}, {24'd0, e.data});
                check("tx_cycle", cyc, e.when);
            end
        end
        if (o_timeout) begin
            if (q_to.size() == 0) begin
                check("unexpected_timeout", 32'd1, 32'd0);
            end else begin
                w = q_to.pop_front();
                check("timeout_cycle", cyc, w);
            end
        end
        if (o_overrun) begin
            if (q_ov.size() == 0) begin
                check("unexpected_overrun", 32'd1, 32'd0);
            end else begin
                w = q_ov.pop_front();
                check("overrun_cycle", cyc, w);
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_rx_done = 1'b1;
        i_rx_data = b;
        @(posedge clk);
        #1;
        i_rx_done = 1'b0;
        i_rx_data = 8'h00;
    endtask

    // Leaves the DUT in EXEC; transmit start is due on the next cycle.
    task automatic issue(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] op, input logic [7:0] exp);
        tx_t e;
        send_byte(a);
        send_byte(b);
        send_byte(op);
        e.data = exp;
        e.when = cyc + 1;
        q_tx.push_back(e);
    endtask

    task automatic tx_done_pulse(input string name);
        i_tx_done = 1'b1;
        wait_cyc(1);
        i_tx_done = 1'b0;
        check(name, {31'd0, o_busy}, 32'd0);
    endtask

    task automatic run_cmd(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] op, input logic [7:0] exp);
        issue(a, b, op, exp);
        wait_cyc(2);
        tx_done_pulse("busy_after_tx_done");
    endtask

    task automatic pulse_reset(input string name);
        i_reset = 1'b0;
        wait_cyc(1);
        i_reset = 1'b1;
        check({name, "_outputs"},
              {o_alu_a, o_alu_b, 2'b00, o_alu_op, o_tx_data}, 32'd0);
        check({name, "_flags"},
              {28'd0, o_tx_start, o_busy, o_timeout, o_overrun}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got running expected finished");
        $fatal(1);
    end

    initial begin
        int k0;
        wait_cyc(3);
        check("reset_outputs", {o_alu_a, o_alu_b, 2'b00, o_alu_op, o_tx_data}, 32'd0);
        check("reset_flags", {28'd0, o_tx_start, o_busy, o_timeout, o_overrun}, 32'd0);
        i_reset = 1'b1;
        wait_cyc(1);

        // Normal command, then busy check mid-command
        send_byte(8'h05);
        check("busy_after_a", {31'd0, o_busy}, 32'd1);
        send_byte(8'h03);
        send_byte(8'h20);
        begin
            tx_t e;
            e.data = 8'h08;
            e.when = cyc + 1;
            q_tx.push_back(e);
        end
        wait_cyc(2);
        tx_done_pulse("busy_after_normal");

        // Back-to-back commands; opcode upper bits are dropped
        run_cmd(8'h10, 8'h04, 8'h22, 8'h0C);
        run_cmd(8'hF0, 8'h3C, 8'h24, 8'h30);
        run_cmd(8'h0F, 8'hA0, 8'hE5, 8'hAF);
        check("opcode_truncated", {26'd0, o_alu_op}, 32'h25);

        // Timeout after operand A only
        send_byte(8'h77);
        k0 = cyc;
        q_to.push_back(k0 + c_T - 1);
        wait_cyc(c_T);
        check("busy_after_timeout", {31'd0, o_busy}, 32'd0);
        check("alu_a_kept_after_timeout", {24'd0, o_alu_a}, 32'h77);
        run_cmd(8'h09, 8'h06, 8'h26, 8'h0F);

        // Opcode arrives on the would-be timeout cycle
        send_byte(8'h20);
        send_byte(8'h22);
        wait_cyc(c_T - 1);
        send_byte(8'h20);
        begin
            tx_t e;
            e.data = 8'h42;
            e.when = cyc + 1;
            q_tx.push_back(e);
        end
        wait_cyc(2);
        tx_done_pulse("busy_after_boundary");

        // Overrun during WAIT_TX
        issue(8'h12, 8'h34, 8'h20, 8'h46);
        wait_cyc(2);
        q_ov.push_back(cyc);
        send_byte(8'hAA);
        check("tx_data_after_overrun", {24'd0, o_tx_data}, 32'h46);
        check("alu_a_after_overrun", {24'd0, o_alu_a}, 32'h12);
        check("busy_after_overrun", {31'd0, o_busy}, 32'd1);
        tx_done_pulse("busy_after_overrun_done");
        run_cmd(8'h80, 8'h01, 8'h22, 8'h7F);

        // Reset mid-command, then during WAIT_TX
        send_byte(8'h55);
        send_byte(8'h66);
        pulse_reset("reset_mid_cmd");
        run_cmd(8'h01, 8'h02, 8'h20, 8'h03);
        issue(8'h40, 8'h40, 8'h20, 8'h80);
        wait_cyc(2);
        pulse_reset("reset_wait_tx");
        run_cmd(8'h03, 8'h04, 8'h20, 8'h07);

        wait_cyc(3);
        check("tx_queue_drained", q_tx.size(), 32'd0);
        check("timeout_queue_drained", q_to.size(), 32'd0);
        check("overrun_queue_drained", q_ov.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
